// File: rtl/counter_ctrl_16bit_if.sv
// counter_ctrl_16bit_if: configuration, command and status bundle for counter_ctrl_16bit.
// The master side is the requester (control/register logic); the slave side is the timer.
// cfg_prescale exists only when TIMER_PRESCALE_EN is defined.

interface counter_ctrl_16bit_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) ();

  // Reject degenerate widths at elaboration.
  if (WIDTH < 2) begin : g_width_check
    $error("counter_ctrl_16bit_if: WIDTH must be at least 2");
  end
  if (PRESCALE_W < 1) begin : g_prescale_w_check
    $error("counter_ctrl_16bit_if: PRESCALE_W must be at least 1");
  end

  // Configuration channel
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [WIDTH-1:0]      cfg_period;
  logic                  cfg_periodic;
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] cfg_prescale;
`endif

  // Single-cycle commands
  logic                  cmd_start;
  logic                  cmd_pause;
  logic                  cmd_stop;
  logic                  irq_ack;

  // Status
  logic [WIDTH-1:0]      count;
  logic [1:0]            state;
  logic                  busy;
  logic                  expire;
  logic                  irq;
  logic                  overrun;

`ifdef TIMER_PRESCALE_EN
  modport master (
    output cfg_valid, cfg_period, cfg_periodic, cfg_prescale,
    output cmd_start, cmd_pause, cmd_stop, irq_ack,
    input  cfg_ready, count, state, busy, expire, irq, overrun
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_periodic, cfg_prescale,
    input  cmd_start, cmd_pause, cmd_stop, irq_ack,
    output cfg_ready, count, state, busy, expire, irq, overrun
  );
`else
  modport master (
    output cfg_valid, cfg_period, cfg_periodic,
    output cmd_start, cmd_pause, cmd_stop, irq_ack,
    input  cfg_ready, count, state, busy, expire, irq, overrun
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_periodic,
    input  cmd_start, cmd_pause, cmd_stop, irq_ack,
    output cfg_ready, count, state, busy, expire, irq, overrun
  );
`endif

endinterface

// File: rtl/counter_ctrl_16bit.sv
// counter_ctrl_16bit: programmable interval-timer controller driving a WIDTH-bit up-counter.
// A period/mode is loaded over a valid/ready handshake; start/pause/stop are single-cycle
// commands with priority stop > pause > start. Emits a one-cycle expire pulse, a sticky irq
// and a sticky overrun flag (expiry while irq still pending).
// Optional feature macro: TIMER_PRESCALE_EN adds cfg_prescale and a PRESCALE_W-bit tick
// prescaler; without it the counter ticks on every clock.

module counter_ctrl_16bit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input logic                 clk,
  input logic                 rst_async,
  counter_ctrl_16bit_if.slave bus
);

  // Reject degenerate widths at elaboration.
  if (WIDTH < 2) begin : g_width_check
    $error("counter_ctrl_16bit: WIDTH must be at least 2");
  end
  if (PRESCALE_W < 1) begin : g_prescale_w_check
    $error("counter_ctrl_16bit: PRESCALE_W must be at least 1");
  end

  localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CountMax = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StArmed  = 2'b01,
    StRun    = 2'b10,
    StPaused = 2'b11
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] count_q;
  logic             periodic_q;
  logic             busy_q;
  logic             expire_q;
  logic             irq_q;
  logic             overrun_q;

  logic [WIDTH-1:0] terminal;
  logic             at_terminal;
  logic             tick;
  logic             run_step;
  logic             expire_evt;

  // ---------------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PscOne = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] psc_cnt_q;

  // One tick every prescale_q + 1 clocks of RUN.
  always_comb begin
    tick = (psc_cnt_q == prescale_q);
  end

  // Prescaler: latched on config, zero outside RUN/PAUSED and on stop, frozen while paused.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      prescale_q <= '0;
      psc_cnt_q  <= '0;
    end else begin
      if (state_q == StIdle && bus.cfg_valid) begin
        prescale_q <= bus.cfg_prescale;
      end
      if (state_q == StIdle || state_q == StArmed) begin
        psc_cnt_q <= '0;
      end else if (bus.cmd_stop) begin
        psc_cnt_q <= '0;
      end else if (run_step) begin
        psc_cnt_q <= tick ? '0 : psc_cnt_q + PscOne;
      end
    end
  end
`else
  // Without a prescaler every clock in RUN is a tick.
  always_comb begin
    tick = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Terminal-count decode
  // ---------------------------------------------------------------------------

  // A zero period means a full 2^WIDTH count, so terminal saturates to all ones.
  always_comb begin
    if (period_q == '0) begin
      terminal = CountMax;
    end else begin
      terminal = period_q - CountOne;
    end
  end

  // run_step: RUN with no stop/pause this cycle; only then can the count advance or expire.
  always_comb begin
    at_terminal = (count_q == terminal);
    run_step    = (state_q == StRun) && !bus.cmd_stop && !bus.cmd_pause;
    expire_evt  = run_step && tick && at_terminal;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered count, busy and expire
  // ---------------------------------------------------------------------------

  // Sequencer: stop > pause > start in every state; pause on the terminal cycle defers expiry.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state_q    <= StIdle;
      period_q   <= '0;
      periodic_q <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      expire_q <= expire_evt;
      unique case (state_q)
        StIdle: begin
          // Commands are ignored here; only a configuration transfer moves us on.
          if (bus.cfg_valid) begin
            period_q   <= bus.cfg_period;
            periodic_q <= bus.cfg_periodic;
            count_q    <= '0;
            state_q    <= StArmed;
          end
        end
        StArmed: begin
          // Pause has no effect of its own but still outranks a simultaneous start.
          if (bus.cmd_stop) begin
            state_q <= StIdle;
            count_q <= '0;
          end else if (!bus.cmd_pause && bus.cmd_start) begin
            state_q <= StRun;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (bus.cmd_stop) begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (bus.cmd_pause) begin
            state_q <= StPaused;
          end else if (tick) begin
            if (at_terminal) begin
              count_q <= '0;
              if (!periodic_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              count_q <= count_q + CountOne;
            end
          end
        end
        StPaused: begin
          if (bus.cmd_stop) begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (!bus.cmd_pause && bus.cmd_start) begin
            state_q <= StRun;
          end
        end
        default: begin
          state_q <= StIdle;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt flags
  // ---------------------------------------------------------------------------

  // Expiry beats ack: an ack coinciding with expiry keeps irq set and overrun as it was.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else if (expire_evt) begin
      irq_q <= 1'b1;
      if (irq_q && !bus.irq_ack) begin
        overrun_q <= 1'b1;
      end
    end else if (bus.irq_ack) begin
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // cfg_ready is a pure state decode so it follows reset without a clock edge.
  assign bus.cfg_ready = (state_q == StIdle);
  assign bus.count     = count_q;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;
  assign bus.expire    = expire_q;
  assign bus.irq       = irq_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_counter_ctrl_16bit.sv
// tb_counter_ctrl_16bit: directed bench for counter_ctrl_16bit. A tick/expiry-count model
// runs alongside the DUT and is compared on every falling edge; directed sequences add
// hand-computed literal checks.

module tb_counter_ctrl_16bit;

  localparam int unsigned W   = 16;
  localparam int unsigned PSW = 8;

  logic clk       = 1'b0;
  logic rst_async = 1'b0;

  int total = 0;
  int bad   = 0;

  counter_ctrl_16bit_if #(.WIDTH(W), .PRESCALE_W(PSW)) bus ();

  counter_ctrl_16bit #(.WIDTH(W), .PRESCALE_W(PSW)) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: counts elapsed ticks since start; count is ticks mod effective period,
  // expiry whenever ticks reaches a multiple of the period.
  // ---------------------------------------------------------------------------
  int m_state    = 0;      // 0 idle, 1 armed, 2 run, 3 paused
  int m_ticks    = 0;
  int m_peff     = 1;
  int m_div      = 1;
  int m_clks     = 0;
  bit m_periodic = 1'b0;
  bit m_expire   = 1'b0;
  bit m_irq      = 1'b0;
  bit m_ovr      = 1'b0;

  always @(posedge clk or negedge rst_async) begin : model
    bit evt;
    if (!rst_async) begin
      m_state  = 0;
      m_ticks  = 0;
      m_clks   = 0;
      m_expire = 1'b0;
      m_irq    = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      evt = 1'b0;
      case (m_state)
        0: if (bus.cfg_valid) begin
          m_peff     = (bus.cfg_period == 0) ? 65536 : int'(bus.cfg_period);
          m_periodic = bus.cfg_periodic;
`ifdef TIMER_PRESCALE_EN
          m_div      = int'(bus.cfg_prescale) + 1;
`else
          m_div      = 1;
`endif
          m_ticks    = 0;
          m_clks     = 0;
          m_state    = 1;
        end
        1: if (bus.cmd_stop) m_state = 0;
           else if (!bus.cmd_pause && bus.cmd_start) begin
             m_state = 2;
             m_ticks = 0;
             m_clks  = 0;
           end
        2: if (bus.cmd_stop) begin
             m_state = 0;
             m_ticks = 0;
             m_clks  = 0;
           end else if (bus.cmd_pause) begin
             m_state = 3;
           end else begin
             m_clks++;
             if (m_clks % m_div == 0) begin
               m_ticks++;
               if (m_ticks % m_peff == 0) begin
                 evt = 1'b1;
                 if (!m_periodic) begin
                   m_state = 0;
                   m_ticks = 0;
                   m_clks  = 0;
                 end
               end
             end
           end
        3: if (bus.cmd_stop) begin
             m_state = 0;
             m_ticks = 0;
             m_clks  = 0;
           end else if (!bus.cmd_pause && bus.cmd_start) begin
             m_state = 2;
           end
        default: m_state = 0;
      endcase
      if (evt) begin
        if (m_irq && !bus.irq_ack) m_ovr = 1'b1;
        m_irq = 1'b1;
      end else if (bus.irq_ack) begin
        m_irq = 1'b0;
        m_ovr = 1'b0;
      end
      m_expire = evt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_count",     longint'(bus.count),     longint'(m_ticks % m_peff));
    check("cmp_state",     longint'(bus.state),     longint'(m_state));
    check("cmp_busy",      longint'(bus.busy),      longint'(m_state >= 2));
    check("cmp_expire",    longint'(bus.expire),    longint'(m_expire));
    check("cmp_irq",       longint'(bus.irq),       longint'(m_irq));
    check("cmp_overrun",   longint'(bus.overrun),   longint'(m_ovr));
    check("cmp_cfg_ready", longint'(bus.cfg_ready), longint'(m_state == 0));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int period, input bit periodic);
    bus.cfg_valid    = 1'b1;
    bus.cfg_period   = W'(period);
    bus.cfg_periodic = periodic;
    next_cycle();
    bus.cfg_valid    = 1'b0;
    check("cfg_to_armed", longint'(bus.state), 1);
  endtask

  task automatic start_cmd();
    bus.cmd_start = 1'b1;
    next_cycle();
    bus.cmd_start = 1'b0;
  endtask

  task automatic ack_cmd();
    bus.irq_ack = 1'b1;
    next_cycle();
    bus.irq_ack = 1'b0;
  endtask

  int irq_tab[18] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int ovr_tab[18] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    bus.cfg_valid    = 1'b0;
    bus.cfg_period   = '0;
    bus.cfg_periodic = 1'b0;
`ifdef TIMER_PRESCALE_EN
    bus.cfg_prescale = '0;
`endif
    bus.cmd_start    = 1'b0;
    bus.cmd_pause    = 1'b0;
    bus.cmd_stop     = 1'b0;
    bus.irq_ack      = 1'b0;

    // Reset state
    repeat (2) next_cycle();
    check("rst_state", longint'(bus.state), 0);
    check("rst_count", longint'(bus.count), 0);
    check("rst_ready", longint'(bus.cfg_ready), 1);
    check("rst_irq",   longint'(bus.irq), 0);
    rst_async = 1'b1;
    next_cycle();

    // Commands in IDLE are ignored
    start_cmd();
    check("idle_start_ignored", longint'(bus.state), 0);

    // One-shot, P = 5
    configure(5, 1'b0);
    start_cmd();
    check("os_start_state", longint'(bus.state), 2);
    check("os_start_count", longint'(bus.count), 0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      check("os_count", longint'(bus.count), i);
      check("os_no_expire", longint'(bus.expire), 0);
    end
    next_cycle();
    check("os_expire", longint'(bus.expire), 1);
    check("os_idle",   longint'(bus.state), 0);
    check("os_irq",    longint'(bus.irq), 1);
    check("os_count0", longint'(bus.count), 0);
    next_cycle();
    check("os_pulse_one_cycle", longint'(bus.expire), 0);
    check("os_ready", longint'(bus.cfg_ready), 1);
    ack_cmd();
    check("os_ack_irq", longint'(bus.irq), 0);

    // Stop while ARMED
    configure(9, 1'b1);
    bus.cmd_stop = 1'b1;
    next_cycle();
    bus.cmd_stop = 1'b0;
    check("armed_stop", longint'(bus.state), 0);

    // Periodic, P = 3: overrun, ack, ack coinciding with expiry
    configure(3, 1'b1);
    start_cmd();
    for (int i = 1; i <= 18; i++) begin
      bus.irq_ack = (i == 8 || i == 12 || i == 18);
      next_cycle();
      bus.irq_ack = 1'b0;
      check("per_count",   longint'(bus.count), i % 3);
      check("per_expire",  longint'(bus.expire), (i % 3) == 0);
      check("per_irq",     longint'(bus.irq), irq_tab[i-1]);
      check("per_overrun", longint'(bus.overrun), ovr_tab[i-1]);
    end
    bus.cmd_stop = 1'b1;
    next_cycle();
    bus.cmd_stop = 1'b0;
    check("per_stop_state", longint'(bus.state), 0);
    check("per_stop_count", longint'(bus.count), 0);
    ack_cmd();
    check("per_ack_irq", longint'(bus.irq), 0);
    check("per_ack_ovr", longint'(bus.overrun), 0);

    // Pause on the terminal cycle, hold 10 cycles, resume
    configure(4, 1'b0);
    start_cmd();
    repeat (3) next_cycle();
    check("pause_pre_count", longint'(bus.count), 3);
    bus.cmd_pause = 1'b1;
    next_cycle();
    bus.cmd_pause = 1'b0;
    check("pause_state",     longint'(bus.state), 3);
    check("pause_no_expire", longint'(bus.expire), 0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("pause_hold_count", longint'(bus.count), 3);
      check("pause_busy",       longint'(bus.busy), 1);
    end
    start_cmd();
    check("resume_state", longint'(bus.state), 2);
    check("resume_count", longint'(bus.count), 3);
    next_cycle();
    check("resume_expire", longint'(bus.expire), 1);
    check("resume_idle",   longint'(bus.state), 0);
    ack_cmd();

    // Stop on the terminal cycle
    configure(4, 1'b1);
    start_cmd();
    repeat (3) next_cycle();
    check("stop_pre_count", longint'(bus.count), 3);
    bus.cmd_stop = 1'b1;
    next_cycle();
    bus.cmd_stop = 1'b0;
    check("stop_no_expire", longint'(bus.expire), 0);
    check("stop_irq",       longint'(bus.irq), 0);
    check("stop_state",     longint'(bus.state), 0);
    check("stop_count",     longint'(bus.count), 0);
    next_cycle();
    check("stop_no_late_expire", longint'(bus.expire), 0);

`ifdef TIMER_PRESCALE_EN
    // Prescale 2, P = 2, one-shot: expiry after 6 clocks
    bus.cfg_prescale = 8'd2;
    configure(2, 1'b0);
    bus.cfg_prescale = '0;
    start_cmd();
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      check("psc_expire", longint'(bus.expire), i == 6);
      if (i >= 3 && i <= 5) check("psc_count", longint'(bus.count), 1);
    end
    ack_cmd();
`endif

    // P = 0 periodic: full 2^16 wrap
    configure(0, 1'b1);
    start_cmd();
    repeat (65535) next_cycle();
    check("wrap_count_max", longint'(bus.count), 65535);
    check("wrap_no_expire", longint'(bus.expire), 0);
    next_cycle();
    check("wrap_expire", longint'(bus.expire), 1);
    check("wrap_count0", longint'(bus.count), 0);
    check("wrap_state",  longint'(bus.state), 2);
    bus.cmd_stop = 1'b1;
    next_cycle();
    bus.cmd_stop = 1'b0;

    // Asynchronous reset mid-RUN at count 7
    configure(20, 1'b1);
    start_cmd();
    repeat (7) next_cycle();
    check("arst_pre_count", longint'(bus.count), 7);
    check("arst_pre_irq",   longint'(bus.irq), 1);
    #2;
    rst_async = 1'b0;
    #1;
    check("arst_count", longint'(bus.count), 0);
    check("arst_state", longint'(bus.state), 0);
    check("arst_irq",   longint'(bus.irq), 0);
    check("arst_ready", longint'(bus.cfg_ready), 1);
    check("arst_busy",  longint'(bus.busy), 0);
    next_cycle();
    rst_async = 1'b1;
    next_cycle();
    check("post_rst_state", longint'(bus.state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl_16bit.md
# counter_ctrl_16bit

Programmable interval-timer controller that sequences a 16-bit up-counter datapath. A requester loads a period and mode through a valid/ready handshake, then starts, pauses, resumes or stops the count with single-cycle commands. The block emits a one-cycle expiry pulse and a sticky interrupt with overrun detection. It sits between the control/register logic and the free-running 16-bit counters used elsewhere in the design.

## Interface
- WIDTH, 16, counter and period width
- PRESCALE_W, 8, prescaler width; used only with TIMER_PRESCALE_EN
- clk  in  1  rising-edge clock
- rst_async  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accepted; equals (state == IDLE)
- cfg_period  in  WIDTH  terminal period; 0 means 2^WIDTH
- cfg_periodic  in  1  1 = auto-reload, 0 = one-shot
- cfg_prescale  in  PRESCALE_W  tick divider − 1; present only with TIMER_PRESCALE_EN
- cmd_start  in  1  start, or resume from pause
- cmd_pause  in  1  freeze count
- cmd_stop  in  1  abort to IDLE
- irq_ack  in  1  clears irq and overrun
- count  out  WIDTH  current count
- state  out  2  IDLE=00, ARMED=01, RUN=10, PAUSED=11
- busy  out  1  state is RUN or PAUSED
- expire  out  1  one-cycle pulse at terminal count
- irq  out  1  sticky expiry flag
- overrun  out  1  sticky; expiry while irq already set

## Operation
- Reset (rst_async = 0, asynchronous):
  - Clears count, expire, irq, overrun and busy to 0 and sets state to IDLE.
  - cfg_ready is 1 while in reset.
- IDLE:
  - A configuration transfers when cfg_valid & cfg_ready.
  - The transfer latches period and mode (and prescale), clears count to 0, and moves to ARMED.
  - Commands are ignored.
- ARMED:
  - cmd_start → RUN with count = 0.
  - cmd_stop → IDLE.
  - cmd_pause is ignored.
- RUN: the count advances by 1 on each tick.
  - Terminal count is count == period − 1, or 2^WIDTH − 1 when the period is 0.
  - At terminal count: count ← 0 and expire ← 1.
  - One-shot mode → IDLE; periodic mode stays in RUN.
- PAUSED:
  - Count holds.
  - cmd_start → RUN.
  - cmd_stop → IDLE with count ← 0.
- Command priority in any state: stop > pause > start.
  - Stop on the terminal-count cycle wins: no expire, no irq.
  - Pause on the terminal-count cycle wins: count holds at terminal, and expiry occurs on the first tick after resume.
- irq and overrun:
  - expire sets irq.
  - expire while irq = 1 and irq_ack = 0 sets overrun.
  - irq_ack clears both flags.
  - irq_ack in the same cycle as expire leaves irq = 1 and overrun unchanged.
- Arithmetic: the count is WIDTH-bit unsigned and never exceeds terminal. Wrap is explicit, never an implicit overflow.

## Timing
- All outputs are registered except cfg_ready, which decodes state.
- Start sampled at edge k: state = RUN and count = 0 after edge k.
- Without prescale, expire is high in the cycle after edge k + P, for period P.
- Periodic mode: expire repeats every P cycles with no dead cycle.
- expire lasts exactly 1 cycle.
- irq rises in the same cycle as expire.
- New configuration is accepted 1 cycle after a one-shot expiry, or after a stop.

## Configuration
- TIMER_PRESCALE_EN defined:
  - Adds cfg_prescale and a PRESCALE_W-bit prescaler.
  - A tick occurs every cfg_prescale + 1 clocks.
  - The prescaler clears on start, stop and configuration, and holds while PAUSED.
  - Expire latency is P × (prescale + 1).
- TIMER_PRESCALE_EN undefined:
  - The cfg_prescale port and the prescaler logic are absent.
  - A tick occurs on every clock.

## Test plan
- Reset mid-RUN at count = 7 → count = 0, state = IDLE, irq = 0, cfg_ready = 1 immediately, without waiting for a clock edge.
- Configure P = 5, one-shot, start at edge k → count 0..4, expire a single pulse after edge k + 5, state = IDLE, irq = 1.
- Configure P = 3, periodic, no ack → expire every 3 cycles; overrun = 1 after the second expire; irq_ack clears both flags.
- Configure P = 4, pause at count = 3 for 10 cycles, then start → count holds at 3; expire on the first tick after resume.
- Stop asserted on the terminal-count cycle → no expire, irq = 0, state = IDLE, count = 0.
- P = 0, periodic → expire after 65536 cycles; count wraps 65535 → 0.
- With TIMER_PRESCALE_EN, prescale = 2 → expire after 3P cycles.
